// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the RV32IM ALU control unit: ALU op codes, aluop
// classes, sequencer state encoding and the decoder result bundle.
package alu_ctrl_pkg;

    localparam int CODE_W = 5;
    typedef logic [CODE_W-1:0] alu_code_t;

    localparam alu_code_t ALU_AND    = 5'd0;
    localparam alu_code_t ALU_OR     = 5'd1;
    localparam alu_code_t ALU_ADD    = 5'd2;
    localparam alu_code_t ALU_SLL    = 5'd3;
    localparam alu_code_t ALU_SLT    = 5'd4;
    localparam alu_code_t ALU_SLTU   = 5'd5;
    localparam alu_code_t ALU_SUB    = 5'd6;
    localparam alu_code_t ALU_XOR    = 5'd7;
    localparam alu_code_t ALU_SRL    = 5'd8;
    localparam alu_code_t ALU_SRA    = 5'd9;
    localparam alu_code_t ALU_MUL    = 5'd10;
    localparam alu_code_t ALU_MULH   = 5'd11;
    localparam alu_code_t ALU_MULHSU = 5'd12;
    localparam alu_code_t ALU_MULHU  = 5'd13;
    localparam alu_code_t ALU_DIV    = 5'd14;
    localparam alu_code_t ALU_DIVU   = 5'd15;
    localparam alu_code_t ALU_REM    = 5'd16;
    localparam alu_code_t ALU_REMU   = 5'd17;

    localparam int ALUOP_MEM = 0;
    localparam int ALUOP_R   = 2;
    localparam int ALUOP_I   = 3;
    localparam int ALUOP_BR  = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        alu_code_t code;
        logic      is_mul;
        logic      is_div;
        logic      illegal;
    } dec_t;

    // Base integer op selected by funct3 when funct7 carries no modifier.
    function automatic alu_code_t base_code(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of aluop/funct3/funct7 into an ALU op code plus
// multi-cycle class flags; unsupported combinations fall back to ADD.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [2:0]         i_funct3,
    input  logic [6:0]         i_funct7,
    output dec_t               o_dec
);

    dec_t w_dec;

    always_comb begin
        w_dec      = '0;
        w_dec.code = ALU_ADD;
        case (i_aluop)
            ALUOP_W'(ALUOP_MEM): w_dec.code = ALU_ADD;
            ALUOP_W'(ALUOP_R): begin
                if (i_funct7 == 7'd0) begin
                    w_dec.code = base_code(i_funct3);
                end else if (i_funct7 == 7'd32) begin
                    if (i_funct3 == 3'd0)      w_dec.code = ALU_SUB;
                    else if (i_funct3 == 3'd5) w_dec.code = ALU_SRA;
                    else                       w_dec.illegal = 1'b1;
                end else if (i_funct7 == 7'd1) begin
                    // M-extension ops are laid out contiguously in funct3 order.
                    w_dec.code   = ALU_MUL + alu_code_t'(i_funct3);
                    w_dec.is_mul = ~i_funct3[2];
                    w_dec.is_div = i_funct3[2];
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            ALUOP_W'(ALUOP_I): begin
                if (i_funct3 != 3'd5)       w_dec.code = base_code(i_funct3);
                else if (i_funct7 == 7'd0)  w_dec.code = ALU_SRL;
                else if (i_funct7 == 7'd32) w_dec.code = ALU_SRA;
                else                        w_dec.illegal = 1'b1;
            end
            ALUOP_W'(ALUOP_BR): begin
                case (i_funct3[2:1])
                    2'd0:    w_dec.code = ALU_XOR;
                    2'd2:    w_dec.code = ALU_SLT;
                    2'd3:    w_dec.code = ALU_SLTU;
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            default: w_dec.illegal = 1'b1;
        endcase
        if (w_dec.illegal) begin
            w_dec.code   = ALU_ADD;
            w_dec.is_mul = 1'b0;
            w_dec.is_div = 1'b0;
        end
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit: decodes each accepted op and, for RV32M
// multiply/divide, holds the unit busy and stalls the front end for its latency.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 4,
    parameter int DEC_W      = 5,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [2:0]         i_funct3,
    input  logic [6:0]         i_funct7,
    output logic [DEC_W-1:0]   o_alu_decode,
    output logic               o_alu_start,
    output logic               o_out_valid,
    output logic               o_stall,
    output logic               o_illegal
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    dec_t             w_dec;
    logic             w_accept;

    state_t           r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [DEC_W-1:0] r_decode,    w_decode_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_start,     w_start_nxt;
    logic             r_stall,     w_stall_nxt;
    logic             r_illegal,   w_illegal_nxt;

    alu_ctrl_dec #(
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .i_aluop  (i_aluop),
        .i_funct3 (i_funct3),
        .i_funct7 (i_funct7),
        .o_dec    (w_dec)
    );

    assign o_in_ready = (r_state == ST_IDLE);
    assign w_accept   = i_in_valid & o_in_ready & ~i_flush;

    // Pulses default low each cycle; flush beats accept and the busy countdown.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_decode_nxt    = r_decode;
        w_out_valid_nxt = 1'b0;
        w_start_nxt     = 1'b0;
        w_stall_nxt     = r_stall;
        w_illegal_nxt   = 1'b0;

        if (i_flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_stall_nxt = 1'b0;
        end else if (w_accept) begin
            w_decode_nxt = DEC_W'(w_dec.code);
            if (w_dec.is_mul || w_dec.is_div) begin
                w_state_nxt = ST_BUSY;
                w_cnt_nxt   = w_dec.is_mul ? MUL_LOAD : DIV_LOAD;
                w_start_nxt = 1'b1;
                w_stall_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b1;
                w_illegal_nxt   = w_dec.illegal;
            end
        end else if (r_state == ST_BUSY) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                w_state_nxt     = ST_IDLE;
                w_stall_nxt     = 1'b0;
                w_out_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_decode    <= '0;
            r_out_valid <= 1'b0;
            r_start     <= 1'b0;
            r_stall     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_decode    <= w_decode_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_start     <= w_start_nxt;
            r_stall     <= w_stall_nxt;
            r_illegal   <= w_illegal_nxt;
        end
    end

    assign o_alu_decode = r_decode;
    assign o_alu_start  = r_start;
    assign o_out_valid  = r_out_valid;
    assign o_stall      = r_stall;
    assign o_illegal    = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: directed scenarios followed by random
// traffic, checked against a behavioural decode/latency model.
module tb_alu_ctrl_seq;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    typedef struct {
        int code;
        bit illegal;
        int lat;
        int due;
    } expect_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [3:0] aluop = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic [4:0] aluDecode;
    logic       aluStart;
    logic       outValid;
    logic       stall;
    logic       illegal;

    expect_t expQ[$];
    int      edgeNo = 0;
    int      busyUntil = 0;
    int      startEdge = -1;
    int      expDecode = 0;
    int      vectors = 0;
    int      miscompares = 0;
    bit      monitorOn = 1'b0;
    bit      expValid;

    alu_ctrl_seq #(
        .ALUOP_W    (4),
        .DEC_W      (5),
        .MUL_CYCLES (MUL_LAT),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_flush      (flush),
        .i_in_valid   (inValid),
        .o_in_ready   (inReady),
        .i_aluop      (aluop),
        .i_funct3     (funct3),
        .i_funct7     (funct7),
        .o_alu_decode (aluDecode),
        .o_alu_start  (aluStart),
        .o_out_valid  (outValid),
        .o_stall      (stall),
        .o_illegal    (illegal)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeNo);
        end
    endtask

    // Reference decode: instruction semantics as mnemonic numbers and latency.
    function automatic expect_t refModel(input int op, input int f3, input int f7);
        int baseOp[8] = '{2, 3, 4, 5, 7, 8, 1, 0};
        expect_t e;
        e.code = 2;
        e.illegal = 1'b0;
        e.lat = 1;
        e.due = 0;
        if (op == 0) begin
            e.code = 2;
        end else if (op == 2) begin
            if (f7 == 0) e.code = baseOp[f3];
            else if (f7 == 32 && f3 == 0) e.code = 6;
            else if (f7 == 32 && f3 == 5) e.code = 9;
            else if (f7 == 1) begin
                e.code = 10 + f3;
                e.lat = (f3 < 4) ? MUL_LAT : DIV_LAT;
            end else e.illegal = 1'b1;
        end else if (op == 3) begin
            if (f3 != 5) e.code = baseOp[f3];
            else if (f7 == 0) e.code = 8;
            else if (f7 == 32) e.code = 9;
            else e.illegal = 1'b1;
        end else if (op == 7) begin
            case (f3 / 2)
                0: e.code = 7;
                1: e.illegal = 1'b1;
                2: e.code = 4;
                default: e.code = 5;
            endcase
        end else begin
            e.illegal = 1'b1;
        end
        if (e.illegal) e.code = 2;
        return e;
    endfunction

    // Drives one cycle of inputs, then records what the coming edge should do.
    task automatic applyStimulus(input bit v, input bit f, input int op, input int f3, input int f7);
        expect_t e;
        bit acc;
        inValid = v;
        flush = f;
        aluop = 4'(op);
        funct3 = 3'(f3);
        funct7 = 7'(f7);
        acc = v && !f && (edgeNo >= busyUntil);
        if (acc) e = refModel(op, f3, f7);
        @(posedge clock);
        edgeNo++;
        if (f) begin
            for (int i = expQ.size() - 1; i >= 0; i--)
                if (expQ[i].due >= edgeNo) expQ.delete(i);
            busyUntil = edgeNo;
        end else if (acc) begin
            e.due = edgeNo + e.lat - 1;
            expQ.push_back(e);
            expDecode = e.code;
            if (e.lat > 1) begin
                busyUntil = e.due;
                startEdge = edgeNo;
            end
        end
        #1;
    endtask

    task automatic doReset(input bit checkNow);
        reset = 1'b1;
        inValid = 1'b0;
        flush = 1'b0;
        #1;
        if (checkNow) begin
            checkOutput("rst_stall", stall, 0);
            checkOutput("rst_out_valid", outValid, 0);
            checkOutput("rst_alu_start", aluStart, 0);
            checkOutput("rst_illegal", illegal, 0);
            checkOutput("rst_decode", aluDecode, 0);
            checkOutput("rst_in_ready", inReady, 1);
        end
        expQ.delete();
        busyUntil = edgeNo;
        startEdge = -1;
        expDecode = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compares every cycle and retires expectations as results appear.
    always @(negedge clock) begin
        if (monitorOn && !reset) begin
            expValid = (expQ.size() > 0) && (expQ[0].due == edgeNo);
            checkOutput("in_ready", inReady, int'(edgeNo >= busyUntil));
            checkOutput("stall", stall, int'(edgeNo < busyUntil));
            checkOutput("alu_start", aluStart, int'(startEdge == edgeNo));
            checkOutput("alu_decode", aluDecode, expDecode);
            checkOutput("out_valid", outValid, int'(expValid));
            if (expValid) begin
                checkOutput("illegal", illegal, int'(expQ[0].illegal));
                void'(expQ.pop_front());
            end else begin
                checkOutput("illegal_idle", illegal, 0);
            end
        end
    end

    initial begin
        int op, f3, f7, sel;
        bit v, f;

        doReset(1'b0);
        monitorOn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] SUB decode");
        applyStimulus(1, 0, 2, 0, 32);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] branch SLTU then load back to back");
        applyStimulus(1, 0, 7, 6, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] MUL with in_valid held");
        repeat (5) applyStimulus(1, 0, 2, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] DIVU flushed at +10");
        applyStimulus(1, 0, 2, 5, 1);
        repeat (9) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 2, 0, 0);
        repeat (30) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] unknown aluop and branch illegal");
        applyStimulus(1, 0, 5, 0, 0);
        applyStimulus(1, 0, 7, 2, 0);
        applyStimulus(1, 0, 3, 5, 32);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] reset during DIV");
        applyStimulus(1, 0, 2, 4, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        doReset(1'b1);
        repeat (2) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 4);
            case (sel)
                0: op = 0;
                1: op = 2;
                2: op = 3;
                3: op = 7;
                default: op = $urandom_range(0, 15);
            endcase
            sel = $urandom_range(0, 3);
            case (sel)
                0: f7 = 0;
                1: f7 = 1;
                2: f7 = 32;
                default: f7 = $urandom_range(0, 127);
            endcase
            f3 = $urandom_range(0, 7);
            if (op == 3 && f3 == 5 && f7 != 0 && f7 != 32) f7 = 0;
            applyStimulus(v, f, op, f3, f7);
        end

        for (int i = 0; i < 40 && expQ.size() > 0; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("drain_pending", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
